// File: rtl/lipsi_pkg.sv
// Shared encodings for the Lipsi accumulator processor: opcode classes,
// ALU/shift/branch function codes and the control state enum.
package lipsi_pkg;

    typedef enum logic [1:0] {FETCH, IMM, HALT} state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBB, ALU_AND, ALU_OR, ALU_XOR, ALU_LD
    } alu_fn_e;

    localparam logic [3:0] OPC_ST    = 4'h8;
    localparam logic [3:0] OPC_BRL   = 4'h9;
    localparam logic [3:0] OPC_LDIND = 4'hA;
    localparam logic [3:0] OPC_STIND = 4'hB;
    localparam logic [3:0] OPC_ALUI  = 4'hC;
    localparam logic [3:0] OPC_BR    = 4'hD;
    localparam logic [3:0] OPC_SHIFT = 4'hE;
    localparam logic [3:0] OPC_IO    = 4'hF;

    localparam logic [1:0] BR_BR   = 2'd0;
    localparam logic [1:0] BR_JMP  = 2'd1;
    localparam logic [1:0] BR_BRZ  = 2'd2;
    localparam logic [1:0] BR_BRNZ = 2'd3;

    localparam logic [1:0] SH_SHL = 2'd0;
    localparam logic [1:0] SH_SHR = 2'd1;
    localparam logic [1:0] SH_ROL = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam logic [7:0] EXIT_OP = 8'hFF;

    // Instructions that carry an operand byte at pc+1.
    function automatic logic is_two_byte(input logic [7:0] ins);
        return (ins[7:4] == OPC_ALUI) || (ins[7:4] == OPC_BR && ins[1:0] != BR_JMP);
    endfunction

endpackage

// File: rtl/lipsi_alu.sv
// Combinational 8-bit ALU; the 9th bit of add/sub becomes carry (borrow on sub).
module lipsi_alu
    import lipsi_pkg::*;
(
    input  logic [7:0] acc_i,
    input  logic [7:0] operand_i,
    input  logic       carry_i,
    input  alu_fn_e    fn_i,
    output logic [7:0] result_o,
    output logic       carry_o
);

    logic [8:0] sum;

    always_comb begin
        sum      = 9'd0;
        result_o = acc_i;
        carry_o  = carry_i;
        case (fn_i)
            ALU_ADD: sum = {1'b0, acc_i} + {1'b0, operand_i};
            ALU_SUB: sum = {1'b0, acc_i} - {1'b0, operand_i};
            ALU_ADC: sum = {1'b0, acc_i} + {1'b0, operand_i} + {8'd0, carry_i};
            ALU_SBB: sum = {1'b0, acc_i} - {1'b0, operand_i} - {8'd0, carry_i};
            ALU_AND: result_o = acc_i & operand_i;
            ALU_OR:  result_o = acc_i | operand_i;
            ALU_XOR: result_o = acc_i ^ operand_i;
            default: result_o = operand_i;
        endcase
        if (fn_i inside {ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBB}) begin
            result_o = sum[7:0];
            carry_o  = sum[8];
        end
    end

endmodule

// File: rtl/tt_um_schoeberl_lipsi.sv
// TinyTapeout tile: Lipsi accumulator CPU with a byte-serial program loader.
// ui_in[7] selects load mode, ui_in[6] strobes a program byte from uio_in.
module tt_um_schoeberl_lipsi
    import lipsi_pkg::*;
#(
    parameter int PROG_AW = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0]         prog_q [2**PROG_AW];
    logic [7:0]         regs_q [16];
    logic [7:0]         pc_q, acc_q, out_q, op_q;
    logic               carry_q;
    logic [PROG_AW-1:0] laddr_q;
    state_e             state_q;

    logic       load, strobe;
    logic [7:0] pc_p1, pc_p2, instr, operand, ind_ptr;
    logic [7:0] alu_b, alu_res;
    logic       alu_c;
    alu_fn_e    alu_fn;

    assign load    = ui_in[7];
    assign strobe  = ui_in[6];
    assign pc_p1   = pc_q + 8'd1;
    assign pc_p2   = pc_q + 8'd2;
    assign instr   = prog_q[pc_q[PROG_AW-1:0]];
    assign operand = prog_q[pc_p1[PROG_AW-1:0]];
    assign ind_ptr = regs_q[instr[3:0]];

    // Register operand in FETCH, immediate byte in IMM.
    assign alu_b  = (state_q == IMM) ? operand : regs_q[instr[3:0]];
    assign alu_fn = (state_q == IMM) ? alu_fn_e'(op_q[2:0]) : alu_fn_e'(instr[6:4]);

    lipsi_alu u_alu (
        .acc_i     (acc_q),
        .operand_i (alu_b),
        .carry_i   (carry_q),
        .fn_i      (alu_fn),
        .result_o  (alu_res),
        .carry_o   (alu_c)
    );

    // Program memory is intentionally not reset.
    always_ff @(posedge clk) begin
        if (load && strobe) prog_q[laddr_q] <= uio_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 8'd0;
            acc_q   <= 8'd0;
            out_q   <= 8'd0;
            op_q    <= 8'd0;
            carry_q <= 1'b0;
            laddr_q <= '0;
            state_q <= FETCH;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'd0;
        end else if (load) begin
            pc_q    <= 8'd0;
            state_q <= FETCH;
            if (strobe) laddr_q <= laddr_q + 1'b1;
        end else begin
            laddr_q <= '0;
            case (state_q)
                FETCH: begin
                    pc_q <= pc_p1;
                    if (instr == EXIT_OP) begin
                        pc_q    <= pc_q;
                        state_q <= HALT;
                    end else if (is_two_byte(instr)) begin
                        pc_q    <= pc_q;
                        op_q    <= instr;
                        state_q <= IMM;
                    end else if (!instr[7]) begin
                        acc_q   <= alu_res;
                        carry_q <= alu_c;
                    end else begin
                        case (instr[7:4])
                            OPC_ST:    regs_q[instr[3:0]] <= acc_q;
                            OPC_BRL: begin
                                regs_q[instr[3:0]] <= pc_p1;
                                pc_q <= acc_q;
                            end
                            OPC_LDIND: acc_q <= regs_q[ind_ptr[3:0]];
                            OPC_STIND: regs_q[ind_ptr[3:0]] <= acc_q;
                            OPC_BR:    pc_q <= acc_q;
                            OPC_SHIFT: begin
                                case (instr[1:0])
                                    SH_SHL:  {carry_q, acc_q} <= {acc_q, 1'b0};
                                    SH_SHR:  {acc_q, carry_q} <= {1'b0, acc_q};
                                    SH_ROL:  {carry_q, acc_q} <= {acc_q, carry_q};
                                    default: {acc_q, carry_q} <= {carry_q, acc_q};
                                endcase
                            end
                            OPC_IO: begin
                                out_q <= acc_q;
                                acc_q <= uio_in;
                            end
                            default: ;
                        endcase
                    end
                end
                IMM: begin
                    state_q <= FETCH;
                    pc_q    <= pc_p2;
                    if (op_q[7:4] == OPC_ALUI) begin
                        acc_q   <= alu_res;
                        carry_q <= alu_c;
                    end else begin
                        case (op_q[1:0])
                            BR_BR:   pc_q <= operand;
                            BR_BRZ:  if (acc_q == 8'd0) pc_q <= operand;
                            default: if (acc_q != 8'd0) pc_q <= operand;
                        endcase
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign uo_out  = out_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused;
    assign unused = &{1'b0, ena, ui_in[5:0]};

endmodule

// File: tb/tb_tt_um_schoeberl_lipsi.sv
// Bench for the Lipsi tile: instruction-level reference model stepped per clock,
// directed programs with literal expectations, then randomized programs.
module tb_tt_um_schoeberl_lipsi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    tt_um_schoeberl_lipsi dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (ISA level) ----------------
    int mprog [32];
    int mr [16];
    int mpc, macc, mc, mout, mladdr;
    bit mwait, mhalt;

    initial for (int i = 0; i < 32; i++) mprog[i] = 255;

    task automatic m_alu(input int fn, input int b);
        int r;
        case (fn)
            0: begin r = macc + b;      mc = (r > 255) ? 1 : 0; macc = r & 255; end
            1: begin r = macc - b;      mc = (r < 0) ? 1 : 0;   macc = r & 255; end
            2: begin r = macc + b + mc; mc = (r > 255) ? 1 : 0; macc = r & 255; end
            3: begin r = macc - b - mc; mc = (r < 0) ? 1 : 0;   macc = r & 255; end
            4: macc = macc & b;
            5: macc = macc | b;
            6: macc = macc ^ b;
            default: macc = b;
        endcase
    endtask

    task automatic m_exec(input int io_val);
        int ins, n, hi, lo, npc, t, p;
        ins = mprog[mpc % 32];
        n   = mprog[(mpc + 1) % 32];
        hi  = ins / 16;
        lo  = ins % 16;
        if (ins == 255) begin mhalt = 1; return; end
        if ((hi == 12 || (hi == 13 && lo % 4 != 1)) && !mwait) begin
            mwait = 1;  // operand cycle still to come; commit then
            return;
        end
        mwait = 0;
        npc = (mpc + 1) % 256;
        if (hi < 8) m_alu(hi, mr[lo]);
        else case (hi)
            8:  mr[lo] = macc;
            9:  begin mr[lo] = npc; npc = macc; end
            10: begin p = mr[lo] % 16; macc = mr[p]; end
            11: begin p = mr[lo] % 16; mr[p] = macc; end
            12: begin m_alu(lo % 8, n); npc = (mpc + 2) % 256; end
            13: case (lo % 4)
                    0: npc = n;
                    1: npc = macc;
                    2: npc = (macc == 0) ? n : (mpc + 2) % 256;
                    default: npc = (macc != 0) ? n : (mpc + 2) % 256;
                endcase
            14: case (lo % 4)
                    0: begin mc = macc / 128; macc = (macc * 2) % 256; end
                    1: begin mc = macc % 2; macc = macc / 2; end
                    2: begin t = mc; mc = macc / 128; macc = (macc * 2) % 256 + t; end
                    default: begin t = mc; mc = macc % 2; macc = macc / 2 + t * 128; end
                endcase
            default: begin mout = macc; macc = io_val; end
        endcase
        mpc = npc;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpc = 0; macc = 0; mc = 0; mout = 0; mladdr = 0; mwait = 0; mhalt = 0;
            for (int i = 0; i < 16; i++) mr[i] = 0;
        end else if (ui_in[7]) begin
            if (ui_in[6]) begin mprog[mladdr] = uio_in; mladdr = (mladdr + 1) % 32; end
            mpc = 0; mwait = 0; mhalt = 0;
        end else begin
            mladdr = 0;
            if (!mhalt) m_exec(int'(uio_in));
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("uo_out_vs_model", uo_out, 8'(mout));
            chk("uio_out", uio_out, 8'h00);
            chk("uio_oe", uio_oe, 8'h00);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [7:0] p[$]);
        @(negedge clk);
        ui_in = 8'hC0;
        for (int i = 0; i < 32; i++) begin
            uio_in = (i < p.size()) ? p[i] : 8'hFF;
            @(negedge clk);
        end
        ui_in  = 8'h00;
        uio_in = 8'h00;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 chk("async_reset_uo_out", uo_out, 8'h00);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] prg[$];
        int n;

        #1 rst_n = 1'b0;
        #1 chk("reset_uo_out", uo_out, 8'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // ld 0x2A ; io ; exit
        prg = '{8'hC7, 8'h2A, 8'hF0, 8'hFF};
        load(prg);
        run(2); chk("ld_io_before", uo_out, 8'h00);
        run(1); chk("ld_io_after", uo_out, 8'h2A);
        run(5); chk("ld_io_halted", uo_out, 8'h2A);

        // ld 5 ; st r0 ; add #3 ; add r0 ; io
        prg = '{8'hC7, 8'h05, 8'h80, 8'hC0, 8'h03, 8'h00, 8'hF0, 8'hFF};
        load(prg);
        run(10); chk("add_reg", uo_out, 8'h0D);
        chk_int("add_reg_carry_model", mc, 0);

        // ld FF ; add #1 -> 0,C=1 ; adc #0 -> 1
        prg = '{8'hC7, 8'hFF, 8'hC0, 8'h01, 8'hC2, 8'h00, 8'hF0, 8'hFF};
        load(prg);
        run(10); chk("adc_overflow", uo_out, 8'h01);

        // ld 0 ; sub #1 -> FF, borrow
        prg = '{8'hC7, 8'h00, 8'hC1, 8'h01, 8'hF0, 8'hFF};
        load(prg);
        run(8); chk("sub_borrow", uo_out, 8'hFF);
        chk_int("sub_borrow_carry_model", mc, 1);

        // countdown loop with brnz
        prg = '{8'hC7, 8'h03, 8'hC1, 8'h01, 8'hD3, 8'h02, 8'hF0, 8'hFF};
        load(prg);
        n = 0;
        while (!mhalt && n < 100) begin @(negedge clk); n++; end
        chk_int("loop_cycles_to_halt", n, 16);
        chk("loop_result", uo_out, 8'h00);

        // two io in a row
        prg = '{8'hF0, 8'hF0, 8'hFF};
        load(prg);
        uio_in = 8'h5A;
        run(1); chk("io_first", uo_out, 8'h00);
        run(1); chk("io_second", uo_out, 8'h5A);

        // endless loop; async reset then rerun from retained memory
        prg = '{8'hC7, 8'h2A, 8'hF0, 8'hD0, 8'h00};
        load(prg);
        run(6); chk("loop_out", uo_out, 8'h2A);
        pulse_reset();
        run(1); chk("after_reset", uo_out, 8'h00);
        run(3); chk("rerun_after_reset", uo_out, 8'h2A);

        // randomized programs with random io input, resets and load pulses
        for (int it = 0; it < 24; it++) begin
            prg = {};
            for (int i = 0; i < 32; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b == 8'hFF && $urandom_range(0, 3) != 0) b = 8'hF1;
                prg.push_back(b);
            end
            load(prg);
            for (int c = 0; c < 150; c++) begin
                int r;
                uio_in = 8'($urandom);
                ui_in  = 8'h00;
                r = $urandom_range(0, 99);
                if (r == 0) pulse_reset();
                else if (r < 3) ui_in = 8'h80;
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
